// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the EX stage
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start_i               M-extension op present in EX with valid operands
//   funct3_i              RV32M operation select
//   op1_i, op2_i          rs1 / rs2 values
//   waddr_i               destination register of the op
//   flush_i               abort the in-flight operation
//   busy_o                holds the front end and ID/EX while an op is in flight
//   valid_o               one-cycle result strobe
//   result_o, waddr_o     registered result and its destination
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      waddr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      waddr_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [4:0]          waddr_q, waddr_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;       // {hi, lo}: product or {remainder, quotient}
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          waddr_out_q, waddr_out_d;

    logic                sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                is_div, div0, ovf;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, div_next, iter;
    logic [XLEN:0]       shifted;
    logic [XLEN+1:0]     diff;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s, rem_s, fin;

    // Operand signedness and magnitudes for the op presented at the input.
    always_comb begin
        sgn1 = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
               (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sgn2 = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
               (funct3_i == 3'b100) || (funct3_i == 3'b110);
        neg1 = sgn1 & op1_i[XLEN-1];
        neg2 = sgn2 & op2_i[XLEN-1];
        mag1 = neg1 ? (~op1_i + 1'b1) : op1_i;
        mag2 = neg2 ? (~op2_i + 1'b1) : op2_i;
        is_div = funct3_i[2];
        div0   = (op2_i == '0);
        ovf    = sgn1 && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    end

    // One radix-2 step of each datapath; the op held in f3_q picks which one is kept.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        shifted  = acc_q[2*XLEN-1:XLEN-1];
        diff     = {1'b0, shifted} - {2'b00, opnd_q};
        div_next = diff[XLEN+1] ? {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0],    acc_q[XLEN-2:0], 1'b1};
        iter     = f3_q[2] ? div_next : mul_next;
        prod_s   = neg_q ? (~iter + 1'b1) : iter;
        quot_s   = neg_q ? (~iter[XLEN-1:0] + 1'b1) : iter[XLEN-1:0];
        rem_s    = neg_q ? (~iter[2*XLEN-1:XLEN] + 1'b1) : iter[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:         fin = prod_s[XLEN-1:0];
            3'b100, 3'b101: fin = quot_s;
            3'b110, 3'b111: fin = rem_s;
            default:        fin = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        waddr_d     = waddr_q;
        neg_d       = neg_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        result_d    = result_q;
        waddr_out_d = waddr_out_q;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    f3_d    = funct3_i;
                    waddr_d = waddr_i;
                    // Remainder takes the dividend's sign; product/quotient the xor.
                    neg_d   = (funct3_i[2] && funct3_i[1]) ? neg1 : (neg1 ^ neg2);
                    opnd_d  = is_div ? mag2 : mag1;
                    acc_d   = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                    if (is_div && (div0 || ovf)) begin
                        if (div0)
                            result_d = funct3_i[1] ? op1_i : '1;
                        else
                            result_d = funct3_i[1] ? '0 : op1_i;
                        waddr_out_d = waddr_i;
                        state_d     = DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    acc_d = iter;
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_d    = fin;
                        waddr_out_d = waddr_q;
                        state_d     = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            waddr_q     <= '0;
            neg_q       <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            waddr_out_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            waddr_q     <= waddr_d;
            neg_q       <= neg_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            waddr_out_q <= waddr_out_d;
        end
    end

    // Combinational on start_i so the accept cycle already stalls ID/EX.
    assign busy_o   = !rst && ((state_q == CALC) ||
                               ((state_q == IDLE) && start_i && !flush_i));
    assign valid_o  = !rst && (state_q == DONE);
    assign result_o = result_q;
    assign waddr_o  = waddr_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  waddr_i;
    logic        flush_i;
    logic        busy_o, valid_o;
    logic [31:0] result_o;
    logic [4:0]  waddr_o;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .waddr_i  (waddr_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o),
        .waddr_o  (waddr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Caller is positioned at a falling edge; this cycle is the accept cycle 0.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa,
                          input logic [31:0] exp, input int lat);
        int cyc = 0;
        int bc  = 0;
        bit seen = 0;
        start_i  = 1'b1;
        funct3_i = f3;
        op1_i    = a;
        op2_i    = b;
        waddr_i  = wa;
        #1;
        while (cyc < 60 && !seen) begin
            if (valid_o) begin
                seen = 1;
            end else begin
                if (busy_o) bc++;
                @(negedge clk);
                cyc++;
                #1;
            end
        end
        check({tag, " valid_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " busy_cycles"}, 32'(bc), 32'(lat));
        check({tag, " busy_in_done"}, 32'(busy_o), 32'd0);
        check({tag, " result"}, result_o, exp);
        check({tag, " waddr"}, 32'(waddr_o), 32'(wa));
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check({tag, " valid_drop"}, 32'(valid_o), 32'd0);
        check({tag, " result_hold"}, result_o, exp);
    endtask

    initial begin
        bit got_valid;
        rst = 1'b1; start_i = 1'b1; funct3_i = 3'b000;
        op1_i = 32'd1; op2_i = 32'd1; waddr_i = 5'd1; flush_i = 1'b0;
        @(negedge clk); #1;
        check("rst busy", 32'(busy_o), 32'd0);
        @(negedge clk); #1;
        check("rst valid", 32'(valid_o), 32'd0);
        check("rst result", result_o, 32'd0);
        check("rst waddr", 32'(waddr_o), 32'd0);
        start_i = 1'b0;
        rst = 1'b0;

        @(negedge clk); run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33);
        @(negedge clk); run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33);
        @(negedge clk); run_op("MULH",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 33);
        @(negedge clk); run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
        @(negedge clk); run_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33);
        @(negedge clk); run_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
        @(negedge clk); run_op("DIVU",   3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       33);
        @(negedge clk); run_op("REMU",   3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        33);
        @(negedge clk); run_op("DIV0",   3'b100, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
        @(negedge clk); run_op("REMOVF", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1);
        @(negedge clk); run_op("REMU0",  3'b111, 32'd77,       32'd0,        5'd13, 32'd77,       1);
        @(negedge clk); run_op("DIVOVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);

        // Flush during CALC cycle 10.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b101; op1_i = 32'd500; op2_i = 32'd3; waddr_i = 5'd15;
        got_valid = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); #1;
            if (valid_o) got_valid = 1;
        end
        flush_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        check("flush busy", 32'(busy_o), 32'd0);
        check("flush valid", 32'(valid_o), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (valid_o) got_valid = 1;
        end
        check("flush no_valid", 32'(got_valid), 32'd0);
        @(negedge clk); run_op("DIVU_after_flush", 3'b101, 32'd1000, 32'd10, 5'd16, 32'd100, 33);

        // Reset during CALC cycle 20 with start held.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b000; op1_i = 32'd3; op2_i = 32'd5; waddr_i = 5'd17;
        for (int i = 1; i <= 20; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy_comb", 32'(busy_o), 32'd0);
        @(negedge clk); #1;
        check("midrst busy", 32'(busy_o), 32'd0);
        check("midrst valid", 32'(valid_o), 32'd0);
        check("midrst result", result_o, 32'd0);
        check("midrst waddr", 32'(waddr_o), 32'd0);
        rst = 1'b0;
        run_op("MUL_after_rst", 3'b000, 32'd3, 32'd5, 5'd17, 32'd15, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage. It executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a radix-2 shift-add or restoring-divide datapath. It drives the `busy` handshake that the pipeline controller uses to hold fetch, decode and the ID/EX register while an operation is in flight. It delivers one result per accepted operation to writeback.

## Interface
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  an M-extension instruction is present in EX with operands valid.
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1_i  in  XLEN  rs1 value.
- op2_i  in  XLEN  rs2 value.
- waddr_i  in  5  destination register.
- flush_i  in  1  abort the in-flight operation (pipeline scour).
- busy_o  out  1  to controller ALU busy input; holds the front end and ID/EX.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  XLEN  result.
- waddr_o  out  5  destination of result_o.

## Operation
- Three states: IDLE, CALC, DONE.
- IDLE
  - With start_i=1 and flush_i=0, latch funct3, waddr, operand magnitudes and sign flags.
  - Fast-path cases go directly to DONE; all other operations go to CALC and clear the counter.
- CALC
  - One iteration per cycle; a 5-bit counter runs 0..31.
  - On count 31, apply sign correction and go to DONE.
- DONE
  - valid_o=1, and result_o/waddr_o are held for this cycle; next state is IDLE.
  - start_i is ignored in DONE, because the same instruction is still presented while ID/EX advances.
- Signedness
  - MUL/MULH/DIV/REM: both operands are signed.
  - MULHSU: op1 is signed, op2 is unsigned.
  - MULHU/DIVU/REMU: both operands are unsigned.
  - The datapath uses magnitudes. The final negation applies when the operand signs differ (product, quotient) or when the dividend is negative (remainder).
- Multiply: 64-bit product. MUL returns [31:0]; MULH* return [63:32].
- Divide fast path (no CALC):
  - op2=0: quotient 0xFFFFFFFF and remainder op1, for both signed and unsigned.
  - Signed op1=0x80000000 with op2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- busy_o = (state==CALC) | (state==IDLE & start_i & ~flush_i). It is combinational on start_i so the accept cycle already holds ID/EX. It is 0 in DONE.
- Flush
  - flush_i in CALC returns to IDLE next cycle; DONE is not entered and valid_o stays 0.
  - flush_i in DONE does not suppress valid_o. The controller never flushes an instruction older than the one in EX.

## Timing
- Reset (rst=1 at an edge) puts the unit in IDLE with valid_o=0, result_o=0 and waddr_o=0. busy_o=0 while rst=1, regardless of start_i.
- Reset mid-CALC discards the operation; the counter and accumulators are cleared.
- Iterative operation:
  - Accept at cycle 0; CALC runs cycles 1..32.
  - DONE/valid_o is asserted in cycle 33.
  - busy_o is high in cycles 0..32 (33 cycles).
- Fast path: busy_o is high in cycle 0 only; valid_o in cycle 1.
- Back-to-back: a new start_i is accepted in the IDLE cycle after DONE, giving a minimum spacing of 34 cycles between accepts.
- result_o and waddr_o are registered and keep their last value outside valid_o.

## Test plan
- MUL 7 × 0xFFFFFFFD -> busy_o high 33 cycles; valid_o in cycle 33 with result_o=0xFFFFFFEB and waddr_o echoed.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH on the same operands -> 0x00000000; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF with valid_o in cycle 1; REM 0x80000000 / 0xFFFFFFFF -> 0 with valid_o in cycle 1.
- flush_i at CALC cycle 10 -> IDLE next cycle; no valid_o; busy_o low. A fresh DIVU is then accepted and completes with the correct result.
- rst at CALC cycle 20 with start_i held high -> busy_o=0, valid_o=0 and result_o=0 while in reset. After release, the held start_i is re-accepted and completes normally.
